zeroheti_obi_demux: RTL
=======================

Name: zeroheti_obi_demux

Overview:
- Single-manager to seven-subordinate OBI address demultiplexer.
- Sits directly downstream of the core data port and consumes the package address map (dbg, imem, dmem, zhic, uart, mtimer, ext).
- Routes each request to the matching subordinate, enforces in-order responses, and answers unmapped accesses from an internal error subordinate.

Parameters:
- MaxTrans, 2, maximum outstanding transactions (1..8).
- AddrMap, zeroheti_pkg::AddrMap, decode rules; indices dbg=0, imem=1, dmem=2, zhic=3, uart=4, mtimer=5, ext=6.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- m_req_i  in  1  manager request
- m_gnt_o  out  1  manager grant
- m_addr_i  in  32  byte address
- m_we_i  in  1  write enable
- m_be_i  in  4  byte enables
- m_wdata_i  in  32  write data
- m_rvalid_o  out  1  response valid
- m_rdata_o  out  32  read data
- m_err_o  out  1  response error
- s_req_o  out  [7]  per-subordinate request
- s_gnt_i  in  [7]  per-subordinate grant
- s_addr_o  out  [7][32]  broadcast address
- s_we_o  out  [7]  broadcast write enable
- s_be_o  out  [7][4]  broadcast byte enables
- s_wdata_o  out  [7][32]  broadcast write data
- s_rvalid_i  in  [7]  per-subordinate response valid
- s_rdata_i  in  [7][32]  per-subordinate read data
- s_err_i  in  [7]  per-subordinate error

Behaviour:
- Decode (combinational): hit when base <= addr < last, last exclusive for all rules. 0xFFFF_FFFF and the range 0xA114..0xFFFF are unmapped and select the error subordinate (index 7 internally).
- State: cnt_q (width $clog2(MaxTrans+1)) and tgt_q (3 bits). Reset: cnt_q=0, tgt_q=0. All outputs 0 after reset.
- Accept condition: m_req_i, cnt_q<MaxTrans, and (cnt_q==0 or decoded target==tgt_q).
- When the accept condition holds, s_req_o[sel]=m_req_i and m_gnt_o=s_gnt_i[sel]. Otherwise no s_req_o is asserted and m_gnt_o=0.
- Address and write fields are broadcast unmasked to all subordinates.
- On handshake (m_req_i & m_gnt_o): tgt_q<=sel and cnt_q increments.
- Response path is combinational from tgt_q: m_rvalid_o=s_rvalid_i[tgt_q], with data and err muxed from the same index. Each response decrements cnt_q.
- Handshake and response in the same cycle: cnt_q is unchanged and tgt_q is updated.
- cnt_q==MaxTrans: m_gnt_o=0 until a response arrives. A request may be granted in the same cycle a response frees a slot only through a registered count, so no combinational rvalid-to-gnt path exists.
- Target switch: a request to a different target stalls until cnt_q==0, then is granted that cycle.
- rvalid from a non-target subordinate is ignored and never forwarded.
- Error subordinate:
  - Grants immediately.
  - Responds exactly one cycle after each grant with rdata=ErrRdata (0xBADC_AB1E) and err=1.
  - Fully pipelined: one grant per cycle, no backpressure.
- Reset mid-operation clears cnt_q, tgt_q and the error pipeline, and drops pending responses. Subordinates share the same reset.

Optional Feature:
- Macro: ZEROHETI_DEMUX_ERR_CAPTURE_EN.
- When defined, adds ports err_addr_o[32], err_we_o, err_valid_o and clr_err_i.
  - The first unmapped handshake captures address and we, and sets err_valid_o.
  - Later errors do not overwrite the capture while err_valid_o=1.
  - clr_err_i clears err_valid_o. If clr_err_i coincides with a new error, the new error wins.
  - All capture registers reset to 0.
- When undefined, none of these ports or registers exist and behaviour is otherwise identical.

Decomposition:
- Add to zeroheti_pkg: NumSubs=7, sub_idx_e enum (DBG..EXT, ERR=7), ErrRdata constant, obi_req_t and obi_rsp_t structs, and a decode function taking addr_map_t and address and returning sub_idx_e.
- Sub-module: zeroheti_obi_err_sub (internal error responder, ~40 lines).

Test Plan:
- Read 0x0000_5004 with dmem gnt=1, rvalid 2 cycles later rdata=0x1234_5678 -> only s_req_o[2] asserted; m_rdata_o=0x1234_5678, m_err_o=0.
- Back-to-back reads to 0x1000 and 0x1004 with imem rvalid delayed 3 cycles -> both granted (cnt=2); third read to 0x1008 stalls until the first response.
- Write to 0x5000 (dmem) then immediate read from 0xA000 (uart) -> uart request withheld until the dmem response; then granted the same cycle cnt reaches 0.
- Read from 0x0000_C000 -> m_gnt_o=1 same cycle; next cycle m_rvalid_o=1, m_err_o=1, m_rdata_o=0xBADC_AB1E; no s_req_o asserted.
- Boundaries 0xA113 -> mtimer, 0xA114 -> error, 0xFFFF_FFFE -> ext, 0xFFFF_FFFF -> error.
- rst_i asserted with cnt=2 outstanding to imem -> next cycle cnt=0, m_gnt_o=0, m_rvalid_o=0. With ZEROHETI_DEMUX_ERR_CAPTURE_EN: error at 0xC000 then 0xD000 -> err_addr_o=0xC000 until clr_err_i.

Source files
------------

// File: rtl/zeroheti_pkg.sv
// Shared SoC definitions: subordinate indices, address map, OBI request/response
// structs and the address decode function used by the data-port demux.
package zeroheti_pkg;

    localparam int NumSubs = 7;
    localparam logic [31:0] ErrRdata = 32'hBADC_AB1E;

    typedef enum logic [2:0] {
        DBG    = 3'd0,
        IMEM   = 3'd1,
        DMEM   = 3'd2,
        ZHIC   = 3'd3,
        UART   = 3'd4,
        MTIMER = 3'd5,
        EXT    = 3'd6,
        ERR    = 3'd7
    } sub_idx_e;

    // end_addr is exclusive for every rule
    typedef struct packed {
        logic [31:0] start_addr;
        logic [31:0] end_addr;
    } addr_rule_t;

    typedef addr_rule_t [NumSubs-1:0] addr_map_t;

    localparam addr_map_t AddrMap = {
        32'h0001_0000, 32'hFFFF_FFFF,  // ext
        32'h0000_A100, 32'h0000_A114,  // mtimer
        32'h0000_A000, 32'h0000_A100,  // uart
        32'h0000_9000, 32'h0000_A000,  // zhic
        32'h0000_5000, 32'h0000_9000,  // dmem
        32'h0000_1000, 32'h0000_5000,  // imem
        32'h0000_0000, 32'h0000_1000   // dbg
    };

    typedef struct packed {
        logic        req;
        logic [31:0] addr;
        logic        we;
        logic [3:0]  be;
        logic [31:0] wdata;
    } obi_req_t;

    typedef struct packed {
        logic        gnt;
        logic        rvalid;
        logic [31:0] rdata;
        logic        err;
    } obi_rsp_t;

    function automatic sub_idx_e decode(input addr_map_t map, input logic [31:0] addr);
        sub_idx_e idx;
        idx = ERR;
        for (int i = 0; i < NumSubs; i++) begin
            if (addr >= map[i].start_addr && addr < map[i].end_addr) begin
                idx = sub_idx_e'(i[2:0]);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/zeroheti_obi_err_sub.sv
// Internal error subordinate: grants every request and answers one cycle later
// with ErrRdata and err set. Fully pipelined, never back-pressures.
module zeroheti_obi_err_sub
    import zeroheti_pkg::*;
(
    input  logic     clk_i,
    input  logic     rst_i,
    input  logic     req_i,
    output obi_rsp_t rsp_o
);

    logic rsp_vld_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rsp_vld_q <= 1'b0;
        end else begin
            rsp_vld_q <= req_i;
        end
    end

    always_comb begin
        rsp_o        = '0;
        rsp_o.gnt    = 1'b1;
        rsp_o.rvalid = rsp_vld_q;
        rsp_o.rdata  = rsp_vld_q ? ErrRdata : 32'h0;
        rsp_o.err    = rsp_vld_q;
    end

endmodule

// File: rtl/zeroheti_obi_demux.sv
// One-manager to seven-subordinate OBI demux with in-order responses and an
// internal error subordinate. ZEROHETI_DEMUX_ERR_CAPTURE_EN adds unmapped-access capture.
module zeroheti_obi_demux
    import zeroheti_pkg::*;
#(
    parameter int unsigned MaxTrans = 2,
    parameter addr_map_t   AddrMap  = zeroheti_pkg::AddrMap
) (
    input  logic                             clk_i,
    input  logic                             rst_i,
    input  logic                             m_req_i,
    output logic                             m_gnt_o,
    input  logic [31:0]                      m_addr_i,
    input  logic                             m_we_i,
    input  logic [3:0]                       m_be_i,
    input  logic [31:0]                      m_wdata_i,
    output logic                             m_rvalid_o,
    output logic [31:0]                      m_rdata_o,
    output logic                             m_err_o,
`ifdef ZEROHETI_DEMUX_ERR_CAPTURE_EN
    output logic [31:0]                      err_addr_o,
    output logic                             err_we_o,
    output logic                             err_valid_o,
    input  logic                             clr_err_i,
`endif
    output logic [NumSubs-1:0]               s_req_o,
    input  logic [NumSubs-1:0]               s_gnt_i,
    output logic [NumSubs-1:0][31:0]         s_addr_o,
    output logic [NumSubs-1:0]               s_we_o,
    output logic [NumSubs-1:0][3:0]          s_be_o,
    output logic [NumSubs-1:0][31:0]         s_wdata_o,
    input  logic [NumSubs-1:0]               s_rvalid_i,
    input  logic [NumSubs-1:0][31:0]         s_rdata_i,
    input  logic [NumSubs-1:0]               s_err_i
);

    localparam int unsigned CntW = $clog2(MaxTrans + 1);
    localparam logic [CntW-1:0] CntMax = CntW'(MaxTrans);
    localparam logic [CntW-1:0] CntOne = CntW'(1);

    logic [CntW-1:0]   cnt_q, cnt_d;
    sub_idx_e          tgt_q, sel;
    obi_req_t          mgr_req;
    obi_rsp_t [NumSubs:0] sub_rsp;
    logic              accept, hs, rsp_vld, err_req;

    assign mgr_req = '{req: m_req_i, addr: m_addr_i, we: m_we_i, be: m_be_i, wdata: m_wdata_i};
    assign sel     = decode(AddrMap, mgr_req.addr);

    // Only one target may have outstanding transactions, which keeps responses in order
    assign accept  = mgr_req.req && (cnt_q < CntMax) && (cnt_q == '0 || sel == tgt_q);
    assign err_req = accept && (sel == ERR);

    for (genvar i = 0; i < NumSubs; i++) begin : g_sub
        assign sub_rsp[i] = '{gnt: s_gnt_i[i], rvalid: s_rvalid_i[i],
                              rdata: s_rdata_i[i], err: s_err_i[i]};
        assign s_addr_o[i]  = mgr_req.addr;
        assign s_we_o[i]    = mgr_req.we;
        assign s_be_o[i]    = mgr_req.be;
        assign s_wdata_o[i] = mgr_req.wdata;
    end

    zeroheti_obi_err_sub i_err_sub (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .req_i (err_req),
        .rsp_o (sub_rsp[NumSubs])
    );

    always_comb begin
        s_req_o = '0;
        if (accept && sel != ERR) begin
            s_req_o[sel] = mgr_req.req;
        end
    end

    assign m_gnt_o = accept && sub_rsp[sel].gnt;
    assign hs      = mgr_req.req && m_gnt_o;

    // Responses only count while something is outstanding; stray rvalids are dropped
    assign rsp_vld    = (cnt_q != '0) && sub_rsp[tgt_q].rvalid;
    assign m_rvalid_o = rsp_vld;
    assign m_rdata_o  = rsp_vld ? sub_rsp[tgt_q].rdata : 32'h0;
    assign m_err_o    = rsp_vld && sub_rsp[tgt_q].err;

    always_comb begin
        cnt_d = cnt_q;
        case ({hs, rsp_vld})
            2'b10:   cnt_d = cnt_q + CntOne;
            2'b01:   cnt_d = cnt_q - CntOne;
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
            tgt_q <= DBG;
        end else begin
            cnt_q <= cnt_d;
            if (hs) begin
                tgt_q <= sel;
            end
        end
    end

`ifdef ZEROHETI_DEMUX_ERR_CAPTURE_EN
    logic [31:0] err_addr_q;
    logic        err_we_q, err_valid_q, new_err;

    assign new_err = hs && (sel == ERR);

    // A clear in the same cycle as a fresh error leaves the fresh error captured
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            err_addr_q  <= '0;
            err_we_q    <= 1'b0;
            err_valid_q <= 1'b0;
        end else if (new_err && (!err_valid_q || clr_err_i)) begin
            err_addr_q  <= mgr_req.addr;
            err_we_q    <= mgr_req.we;
            err_valid_q <= 1'b1;
        end else if (clr_err_i) begin
            err_valid_q <= 1'b0;
        end
    end

    assign err_addr_o  = err_addr_q;
    assign err_we_o    = err_we_q;
    assign err_valid_o = err_valid_q;
`endif

endmodule
